// File: rtl/fetch_decode_unit_if.sv
// Bundle for the fetch/decode unit: instruction-memory port, execute redirect and the
// decoded-instruction issue port. The unit itself uses the master view.
interface fetch_decode_unit_if #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned IMM_W = 8
);
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_valid;
  logic [15:0]      imem_rdata;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_target;
  logic             dec_valid;
  logic             dec_ready;
  logic [PC_W-1:0]  dec_pc;
  logic [4:0]       op;
  logic [2:0]       rd;
  logic [2:0]       rs1;
  logic [2:0]       rs2;
  logic [IMM_W-1:0] imm;
  logic             imm_mode;
  logic             is_load;
  logic             is_store;
  logic             is_jmp;
  logic             is_branch;
  logic             illegal;
  logic             done;

  modport master (
    output imem_req, imem_addr,
    input  imem_valid, imem_rdata,
    input  redirect_valid, redirect_target,
    output dec_valid,
    input  dec_ready,
    output dec_pc, op, rd, rs1, rs2, imm,
    output imm_mode, is_load, is_store, is_jmp, is_branch, illegal, done
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_valid, imem_rdata,
    output redirect_valid, redirect_target,
    input  dec_valid,
    output dec_ready,
    input  dec_pc, op, rd, rs1, rs2, imm,
    input  imm_mode, is_load, is_store, is_jmp, is_branch, illegal, done
  );
endinterface

// File: rtl/fetch_decode_unit.sv
// Fetches 16-bit instructions one at a time, decodes them into registered fields and
// issues them to execute; resolves jumps locally, follows redirects and halts.
module fetch_decode_unit #(
  parameter int unsigned     PC_W      = 8,
  parameter int unsigned     IMM_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [PC_W-1:0] HALT_ADDR = '1
) (
  input logic                 clk,
  input logic                 reset,
  fetch_decode_unit_if.master bus
);

  typedef enum logic [2:0] {S_FETCH, S_WAIT, S_HOLD, S_DRAIN, S_HALTED} state_t;

  typedef struct packed {
    logic [4:0]       op;
    logic [2:0]       rd;
    logic [2:0]       rs1;
    logic [2:0]       rs2;
    logic [IMM_W-1:0] imm;
    logic             imm_mode;
    logic             is_load;
    logic             is_store;
    logic             is_jmp;
    logic             is_branch;
    logic             illegal;
  } dec_t;

  localparam logic [4:0] OP_LOAD  = 5'd17;
  localparam logic [4:0] OP_STORE = 5'd24;
  localparam logic [4:0] OP_JMP   = 5'd30;
  localparam logic [4:0] OP_HALT  = 5'd31;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, dec_pc_q, dec_pc_d, jmp_off;
  dec_t            dec_q, dec_d, dec_new;
  logic            dec_valid_q, dec_valid_d, done_q, done_d;
  logic            armed_q, req;
  logic [15:0]     instr;

  assign instr   = bus.imem_rdata;
  assign jmp_off = PC_W'($signed(instr[7:0]));

  // NOTE: every field gets a default before the case, so no path leaves a latch behind.
  always_comb begin
    dec_new    = '0;
    dec_new.op = instr[15:11];
    case (instr[15:11]) inside
      [5'd0:5'd11]: begin
        dec_new.rd  = instr[10:8];
        dec_new.rs1 = instr[7:5];
        dec_new.rs2 = instr[4:2];
      end
      [5'd16:5'd20]: begin
        dec_new.rd       = instr[10:8];
        dec_new.rs1      = instr[7:5];
        dec_new.imm      = IMM_W'($signed(instr[4:0]));
        dec_new.imm_mode = 1'b1;
        dec_new.is_load  = (instr[15:11] == OP_LOAD);
      end
      OP_STORE: begin
        dec_new.rs2      = instr[10:8];
        dec_new.rs1      = instr[7:5];
        dec_new.imm      = IMM_W'($signed(instr[4:0]));
        dec_new.imm_mode = 1'b1;
        dec_new.is_store = 1'b1;
      end
      [5'd25:5'd28]: begin
        dec_new.rs1       = instr[10:8];
        dec_new.rs2       = instr[7:5];
        dec_new.imm       = IMM_W'($signed(instr[4:0]));
        dec_new.is_branch = 1'b1;
      end
      OP_JMP: begin
        dec_new.imm    = IMM_W'($signed(instr[7:0]));
        dec_new.is_jmp = 1'b1;
      end
      default: dec_new.illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    dec_pc_d    = dec_pc_q;
    dec_d       = dec_q;
    dec_valid_d = dec_valid_q;
    done_d      = done_q;

    unique case (state_q)
      S_FETCH: if (req) state_d = S_WAIT;
      S_WAIT: begin
        if (bus.imem_valid) begin
          if (dec_new.op == OP_HALT) begin
            done_d  = 1'b1;
            state_d = S_HALTED;
          end else begin
            dec_d       = dec_new;
            dec_pc_d    = pc_q;
            dec_valid_d = 1'b1;
            pc_d        = dec_new.is_jmp ? pc_q + jmp_off : pc_q + PC_W'(1);
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (bus.dec_ready) begin
          dec_valid_d = 1'b0;
          if (dec_pc_q == HALT_ADDR) begin
            done_d  = 1'b1;
            state_d = S_HALTED;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_DRAIN:  if (bus.imem_valid) state_d = S_FETCH;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase

    // Redirect overrides everything above; a response arriving on the same edge
    // leaves nothing outstanding, so there is nothing to drain.
    if (bus.redirect_valid && state_q != S_HALTED) begin
      pc_d        = bus.redirect_target;
      dec_pc_d    = dec_pc_q;
      dec_d       = dec_q;
      dec_valid_d = 1'b0;
      done_d      = done_q;
      if (state_q == S_WAIT || state_q == S_DRAIN)
        state_d = bus.imem_valid ? S_FETCH : S_DRAIN;
      else
        state_d = S_FETCH;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      dec_pc_q    <= '0;
      dec_q       <= '0;
      dec_valid_q <= 1'b0;
      done_q      <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      dec_pc_q    <= dec_pc_d;
      dec_q       <= dec_d;
      dec_valid_q <= dec_valid_d;
      done_q      <= done_d;
      armed_q     <= 1'b1;
    end
  end

  // armed_q keeps the request low during reset; a redirect in FETCH defers the
  // request one cycle so the old address is never fetched.
  assign req = (state_q == S_FETCH) && armed_q && !bus.redirect_valid;

  assign bus.imem_req  = req;
  assign bus.imem_addr = req ? pc_q : '0;
  assign bus.dec_valid = dec_valid_q;
  assign bus.dec_pc    = dec_pc_q;
  assign bus.op        = dec_q.op;
  assign bus.rd        = dec_q.rd;
  assign bus.rs1       = dec_q.rs1;
  assign bus.rs2       = dec_q.rs2;
  assign bus.imm       = dec_q.imm;
  assign bus.imm_mode  = dec_q.imm_mode;
  assign bus.is_load   = dec_q.is_load;
  assign bus.is_store  = dec_q.is_store;
  assign bus.is_jmp    = dec_q.is_jmp;
  assign bus.is_branch = dec_q.is_branch;
  assign bus.illegal   = dec_q.illegal;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Scoreboard bench for fetch_decode_unit: directed programs push expected fetches and
// decodes; monitors compare them whenever the unit requests or presents an instruction.
module tb_fetch_decode_unit;

  typedef struct packed {
    logic [7:0] pc;
    logic [4:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [7:0] imm;
    logic [5:0] flags;  // imm_mode, is_load, is_store, is_jmp, is_branch, illegal
  } dec_exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   mem_lat  = 1;
  logic [15:0] mem [256];
  logic [7:0]  exp_fetch [$];
  dec_exp_t    exp_dec [$];

  always #5 clk = ~clk;

  fetch_decode_unit_if #(.PC_W(8), .IMM_W(8)) bus ();

  fetch_decode_unit #(
    .PC_W(8), .IMM_W(8), .RESET_PC(8'h00), .HALT_ADDR(8'h04)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic note_fail(input string name, input string what);
    n_checks++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic dec_exp_t mk(input logic [7:0] pc, input logic [4:0] op,
                                  input logic [2:0] rd, input logic [2:0] rs1,
                                  input logic [2:0] rs2, input logic [7:0] imm,
                                  input logic [5:0] flags);
    mk = '{pc, op, rd, rs1, rs2, imm, flags};
  endfunction

  function automatic dec_exp_t cur_dec();
    cur_dec = '{bus.dec_pc, bus.op, bus.rd, bus.rs1, bus.rs2, bus.imm,
                {bus.imm_mode, bus.is_load, bus.is_store, bus.is_jmp, bus.is_branch, bus.illegal}};
  endfunction

  // Memory responder: one response per request after mem_lat cycles.
  initial begin
    logic [7:0] a;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset && bus.imem_req) begin
        a = bus.imem_addr;
        repeat (mem_lat) @(posedge clk);
        #1;
        bus.imem_valid = 1'b1;
        bus.imem_rdata = mem[a];
        @(posedge clk);
        #1;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
      end
    end
  end

  // Monitor: fetch addresses and presented decodes against the scoreboard queues.
  always @(negedge clk) begin
    if (!reset && bus.imem_req) begin
      if (exp_fetch.size() == 0)
        note_fail("imem_addr", $sformatf("got unexpected fetch of %0h, expected none", bus.imem_addr));
      else
        check("imem_addr", 64'(bus.imem_addr), 64'(exp_fetch.pop_front()));
    end
    if (!reset && bus.dec_valid) begin
      if (exp_dec.size() == 0)
        note_fail("dec_valid", $sformatf("got unexpected decode at pc %0h, expected none", bus.dec_pc));
      else begin
        check($sformatf("decode pc=%0h", exp_dec[0].pc), 64'(cur_dec()), 64'(exp_dec[0]));
        if (bus.dec_ready) void'(exp_dec.pop_front());
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, " imem_req"},  64'(bus.imem_req), 64'd0);
    check({tag, " imem_addr"}, 64'(bus.imem_addr), 64'd0);
    check({tag, " dec_valid"}, 64'(bus.dec_valid), 64'd0);
    check({tag, " done"},      64'(bus.done), 64'd0);
    check({tag, " fields"},    64'(cur_dec()), 64'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("imem_req while arming", 64'(bus.imem_req), 64'd0);
    @(negedge clk);
    check("first imem_req after reset", 64'(bus.imem_req), 64'd1);
  endtask

  task automatic wait_dec(input logic [7:0] pc);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.dec_valid && bus.dec_pc == pc) return;
    end
    note_fail("wait_dec", $sformatf("no decode at pc %0h within 60 cycles", pc));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    note_fail("wait_done", "done never rose within 60 cycles");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.dec_ready       = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h0A44;  // R  op1 rd2 rs1=2 rs2=1
    mem[8'h01] = 16'h8B9E;  // I  op17 load rd3 rs1=4 imm=-2
    mem[8'h02] = 16'hF0FC;  // J  imm=-4 -> pc FE
    mem[8'hFE] = 16'hC5C7;  // S  rs2=5 rs1=6 imm=7
    mem[8'hFF] = 16'hC9F0;  // B  rs1=1 rs2=7 imm=-16, then pc wraps to 0
    mem[8'h05] = 16'hF0FC;  // J at 5 -> pc 1
    mem[8'h40] = 16'h6FFF;  // op 13: illegal
    mem[8'h41] = 16'h872F;  // I  op16 rd7 rs1=1 imm=15
    mem[8'h42] = 16'h594C;  // R  op11 rd1 rs1=2 rs2=3

    repeat (2) @(negedge clk);
    check_idle("initial reset");

    // Sequential flow, jump backwards with wrap, wrap FF -> 00.
    foreach (mem[i]) begin end
    exp_fetch = '{8'h00, 8'h01, 8'h02, 8'hFE, 8'hFF, 8'h00};
    exp_dec.push_back(mk(8'h00, 5'd1,  3'd2, 3'd2, 3'd1, 8'h00, 6'b000000));
    exp_dec.push_back(mk(8'h01, 5'd17, 3'd3, 3'd4, 3'd0, 8'hFE, 6'b110000));
    exp_dec.push_back(mk(8'h02, 5'd30, 3'd0, 3'd0, 3'd0, 8'hFC, 6'b000100));
    exp_dec.push_back(mk(8'hFE, 5'd24, 3'd0, 3'd6, 3'd5, 8'h07, 6'b101000));
    exp_dec.push_back(mk(8'hFF, 5'd25, 3'd0, 3'd1, 3'd7, 8'hF0, 6'b000010));
    exp_dec.push_back(mk(8'h00, 5'd1,  3'd2, 3'd2, 3'd1, 8'h00, 6'b000000));
    release_reset();
    wait_dec(8'h00);
    repeat (3) @(posedge clk);
    #1;
    bus.dec_ready = 1'b1;
    wait_dec(8'hFF);
    @(posedge clk);
    #1;
    bus.dec_ready = 1'b0;
    wait_dec(8'h00);

    // Reset while an instruction is held.
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_idle("reset mid-HOLD");
    check("held entries at reset", 64'(exp_dec.size()), 64'd1);
    check("fetches at reset", 64'(exp_fetch.size()), 64'd0);
    exp_dec.delete();
    exp_fetch.delete();

    // Redirect in WAIT drops the stale response; redirect with handshake in HOLD; HALT.
    mem[8'h01] = 16'h0000;
    mem[8'h02] = 16'h0000;
    mem[8'h03] = 16'hF800;
    mem_lat = 3;
    exp_fetch = '{8'h00, 8'h40, 8'h41, 8'h42, 8'h05, 8'h01, 8'h02, 8'h03};
    exp_dec.push_back(mk(8'h40, 5'd13, 3'd0, 3'd0, 3'd0, 8'h00, 6'b000001));
    exp_dec.push_back(mk(8'h41, 5'd16, 3'd7, 3'd1, 3'd0, 8'h0F, 6'b100000));
    exp_dec.push_back(mk(8'h42, 5'd11, 3'd1, 3'd2, 3'd3, 8'h00, 6'b000000));
    exp_dec.push_back(mk(8'h05, 5'd30, 3'd0, 3'd0, 3'd0, 8'hFC, 6'b000100));
    exp_dec.push_back(mk(8'h01, 5'd0,  3'd0, 3'd0, 3'd0, 8'h00, 6'b000000));
    exp_dec.push_back(mk(8'h02, 5'd0,  3'd0, 3'd0, 3'd0, 8'h00, 6'b000000));
    release_reset();
    @(posedge clk);
    #1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 8'h40;
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    mem_lat = 1;
    bus.dec_ready = 1'b1;
    wait_dec(8'h42);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 8'h05;
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    wait_done();
    check("HALT dec_valid", 64'(bus.dec_valid), 64'd0);
    check("HALT done", 64'(bus.done), 64'd1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 8'h10;
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("done sticky after redirect", 64'(bus.done), 64'd1);
    check("halt phase fetches left", 64'(exp_fetch.size()), 64'd0);
    check("halt phase decodes left", 64'(exp_dec.size()), 64'd0);

    // Sequential flow up to HALT_ADDR = 4.
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_idle("reset after halt");
    mem[8'h03] = 16'h594C;
    mem[8'h04] = 16'h8B9E;
    exp_fetch = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    exp_dec.push_back(mk(8'h00, 5'd1,  3'd2, 3'd2, 3'd1, 8'h00, 6'b000000));
    exp_dec.push_back(mk(8'h01, 5'd0,  3'd0, 3'd0, 3'd0, 8'h00, 6'b000000));
    exp_dec.push_back(mk(8'h02, 5'd0,  3'd0, 3'd0, 3'd0, 8'h00, 6'b000000));
    exp_dec.push_back(mk(8'h03, 5'd11, 3'd1, 3'd2, 3'd3, 8'h00, 6'b000000));
    exp_dec.push_back(mk(8'h04, 5'd17, 3'd3, 3'd4, 3'd0, 8'hFE, 6'b110000));
    release_reset();
    wait_dec(8'h03);
    @(posedge clk);
    #1;
    bus.dec_ready = 1'b0;
    wait_dec(8'h04);
    check("done before HALT_ADDR handshake", 64'(bus.done), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    bus.dec_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("done after HALT_ADDR handshake", 64'(bus.done), 64'd1);
    check("dec_valid after HALT_ADDR handshake", 64'(bus.dec_valid), 64'd0);
    repeat (10) @(negedge clk);
    check("final fetches left", 64'(exp_fetch.size()), 64'd0);
    check("final decodes left", 64'(exp_dec.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
